// File: rtl/blitter_engine.sv
// Tile-map blitter: walks every map cell and tile pixel and copies the sprite pixels into the back frame buffer.
// Latency: 2 + 3*TILE_PX^2 cycles per cell when FB_Ready stays high; FB_Ready low stalls WRITE with address, data and FB_WE held.
module blitter_engine #(
    parameter int MAP_W      = 15,
    parameter int MAP_H      = 13,
    parameter int TILE_PX    = 16,
    parameter int TILE_IDX_W = 4,
    parameter int PIX_W      = 8,
    parameter int MAP_AW     = 8,
    parameter int SPR_AW     = 12,
    parameter int FB_AW      = 17
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Status,
    output logic                  Flip_Blitter,
    output logic                  Busy,
    output logic                  Draw_Buf,
    output logic [MAP_AW-1:0]     Map_Addr,
    input  logic [TILE_IDX_W-1:0] Map_Data,
    output logic [SPR_AW-1:0]     Spr_Addr,
    input  logic [PIX_W-1:0]      Spr_Data,
    output logic [FB_AW-1:0]      FB_Addr,
    output logic [PIX_W-1:0]      FB_Data,
    output logic                  FB_WE,
    input  logic                  FB_Ready
);

    localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int PX_W  = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
    localparam int LIN_W = FB_AW - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MAP_REQ = 3'd1,
        MAP_LAT = 3'd2,
        SPR_REQ = 3'd3,
        SPR_LAT = 3'd4,
        WRITE   = 3'd5,
        FLIP    = 3'd6
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [PX_W-1:0]       px;
    logic [PX_W-1:0]       py;
    logic [TILE_IDX_W-1:0] tile;
    logic [PIX_W-1:0]      pix;
    logic                  draw_buf;

    logic                  px_last;
    logic                  py_last;
    logic                  col_last;
    logic                  row_last;
    logic                  pix_last;
    logic                  cell_last;

    logic [31:0]           pix_x;
    logic [31:0]           pix_y;
    logic [31:0]           fb_lin;

    assign px_last   = (px  == PX_W'(TILE_PX - 1));
    assign py_last   = (py  == PX_W'(TILE_PX - 1));
    assign col_last  = (col == COL_W'(MAP_W - 1));
    assign row_last  = (row == ROW_W'(MAP_H - 1));
    assign pix_last  = px_last && py_last;
    assign cell_last = col_last && row_last;

    // Addresses are pure functions of the counter registers, so they stay
    // stable for as long as the FSM dwells in a state (including WRITE stalls).
    assign pix_x  = 32'(col) * TILE_PX + 32'(px);
    assign pix_y  = 32'(row) * TILE_PX + 32'(py);
    assign fb_lin = pix_y * (MAP_W * TILE_PX) + pix_x;

    assign Map_Addr = MAP_AW'(32'(row) * MAP_W + 32'(col));
    assign Spr_Addr = SPR_AW'(32'(tile) * (TILE_PX * TILE_PX) + 32'(py) * TILE_PX + 32'(px));
    assign FB_Addr  = {draw_buf, LIN_W'(fb_lin)};
    assign FB_Data  = pix;
    assign Draw_Buf = draw_buf;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Status) next_state = MAP_REQ;
            MAP_REQ: next_state = MAP_LAT;
            MAP_LAT: next_state = SPR_REQ;
            SPR_REQ: next_state = SPR_LAT;
            SPR_LAT: next_state = WRITE;
            WRITE: begin
                if (FB_Ready) begin
                    if (!pix_last) begin
                        next_state = SPR_REQ;
                    end else if (!cell_last) begin
                        next_state = MAP_REQ;
                    end else begin
                        next_state = FLIP;
                    end
                end
            end
            FLIP:    if (!Status) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Busy         = (state != IDLE);
        FB_WE        = (state == WRITE);
        Flip_Blitter = (state == FLIP);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col      <= '0;
            row      <= '0;
            px       <= '0;
            py       <= '0;
            tile     <= '0;
            pix      <= '0;
            draw_buf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Status) begin
                        col <= '0;
                        row <= '0;
                        px  <= '0;
                        py  <= '0;
                    end
                end
                MAP_LAT: tile <= Map_Data;
                SPR_LAT: pix  <= Spr_Data;
                WRITE: begin
                    // The final pixel of the final cell leaves every counter parked.
                    if (FB_Ready) begin
                        if (!px_last) begin
                            px <= px + 1'b1;
                        end else if (!py_last) begin
                            px <= '0;
                            py <= py + 1'b1;
                        end else if (!cell_last) begin
                            px <= '0;
                            py <= '0;
                            if (!col_last) begin
                                col <= col + 1'b1;
                            end else begin
                                col <= '0;
                                row <= row + 1'b1;
                            end
                        end
                    end
                end
                FLIP: if (!Status) draw_buf <= ~draw_buf;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/blitter_engine.md
BLITTER_ENGINE -- requirements
Module: blitter_engine

Interface
REQ-001 SHALL be built on one clock; reset is asynchronous and active-low.
REQ-002 SHALL take parameters: MAP_W, default 15, grid columns. MAP_H, default 13, grid rows. TILE_PX, default 16, tile edge in pixels (power of 2). TILE_IDX_W, default 4, tile index width. PIX_W, default 8, pixel width. MAP_AW, default 8, map address width. SPR_AW, default 12, sprite address width. FB_AW, default 17, frame-buffer address width including buffer-select MSB.
REQ-003 SHALL have ports:
- Clk  in  1  system clock.
- Reset_n  in  1  async active-low reset.
- Status  in  1  frame-request flag from the status register; 1 = draw requested.
- Flip_Blitter  out  1  frame-done flag to the status register.
- Busy  out  1  high whenever not IDLE.
- Draw_Buf  out  1  back buffer currently being drawn.
- Map_Addr  out  MAP_AW  tile-map RAM address.
- Map_Data  in  TILE_IDX_W  tile index, valid one cycle after address.
- Spr_Addr  out  SPR_AW  sprite ROM address.
- Spr_Data  in  PIX_W  pixel, valid one cycle after address.
- FB_Addr  out  FB_AW  frame-buffer write address.
- FB_Data  out  PIX_W  frame-buffer write data.
- FB_WE  out  1  write request.
- FB_Ready  in  1  write accepted when high with FB_WE.

Function
REQ-004 SHALL implement FSM states: IDLE, MAP_REQ, MAP_LAT, SPR_REQ, SPR_LAT, WRITE, FLIP; all outputs registered or Moore-decoded.
REQ-005 In IDLE, Status=1 sampled SHALL clear cell/pixel counters and go to MAP_REQ; Status=0 SHALL hold IDLE.
REQ-006 MAP_REQ SHALL drive Map_Addr = row*MAP_W+col and go to MAP_LAT; MAP_LAT SHALL latch Map_Data into tile register and go to SPR_REQ.
REQ-007 SPR_REQ SHALL drive Spr_Addr = tile*TILE_PX^2 + py*TILE_PX + px and go to SPR_LAT; SPR_LAT SHALL latch Spr_Data into FB_Data and go to WRITE.
REQ-008 WRITE SHALL drive FB_WE=1, FB_Addr = {Draw_Buf, y*(MAP_W*TILE_PX)+x}, x=col*TILE_PX+px, y=row*TILE_PX+py, zero-extended to FB_AW-1 bits.
REQ-009 While FB_WE=1 and FB_Ready=0, FB_Addr, FB_Data, FB_WE SHALL hold stable; write completes on the edge sampling FB_Ready=1.
REQ-010 On write completion: next pixel (px then py, row-major) -> SPR_REQ; last pixel of tile -> next cell (col then row) -> MAP_REQ; last pixel of last cell -> FLIP.
REQ-011 With FB_Ready=1 throughout, FLIP SHALL be entered exactly MAP_W*MAP_H*(2+3*TILE_PX^2) edges after the edge sampling Status=1.
REQ-012 In FLIP, Flip_Blitter SHALL be 1 and held until Status sampled 0; on that edge SHALL toggle Draw_Buf, drop Flip_Blitter, return to IDLE.
REQ-013 Status changes during MAP_REQ..WRITE SHALL be ignored; counters SHALL not wrap beyond last cell.
REQ-014 FB_WE SHALL be 0 in every state except WRITE; Busy SHALL be 0 only in IDLE.

Reset
REQ-015 Reset_n=0 SHALL immediately force IDLE, Flip_Blitter=0, Busy=0, Draw_Buf=0, FB_WE=0, all addresses, FB_Data and counters to 0, regardless of state.
REQ-016 Operation SHALL resume only after Reset_n=1 and Status=1 sampled in IDLE.

Verification (MAP_W=2, MAP_H=1, TILE_PX=2, TILE_IDX_W=2, FB_AW=4, sprite ROM data = address)
REQ-017 Map={1,2}, FB_Ready=1, Status pulse -> 8 writes, FB_Addr 0,1,4,5,2,3,6,7, FB_Data 4,5,6,7,8,9,10,11; Flip_Blitter=1 28 edges after Status sampled.
REQ-018 FB_Ready=0 for 3 cycles on first write -> FB_WE/FB_Addr=0/FB_Data=4 held 4 cycles; Flip_Blitter at edge 31.
REQ-019 Status held 1 after Flip_Blitter=1 -> Flip_Blitter stays 1; Status->0 -> next edge Flip_Blitter=0, Draw_Buf=1; second frame FB_Addr 8,9,12,13,10,11,14,15.
REQ-020 Status=0 for 100 cycles in IDLE -> Busy=0, FB_WE=0, no address change.
REQ-021 Reset_n=0 during WRITE with FB_Ready=0 -> FB_WE=0, Busy=0 immediately, without a clock edge.
REQ-022 Reset_n=0 during FLIP after one completed frame (Draw_Buf=1) -> Draw_Buf=0, Flip_Blitter=0.
